uart_tx_arb: RTL

- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. cmd_int read responses and a debug/event stream.
- Grants at packet granularity: the owner keeps the transmitter until its byte flagged last has been sent.
- Sequences the UART `transmit` / `is_transmitting` handshake one byte at a time and drives `tx_byte`.
- Sits between the requesters and the uart instance inside design_top.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arb_rr_pick.sv | 45 ++++
 rtl/uart_tx_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEF_START_TIMEOUT = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_START,
        WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational requester picker for uart_tx_arb.
// Default: round-robin, searching upward from ptr_i and wrapping.
// With UART_TX_ARB_FIXED_PRIO_EN defined: lowest index wins, ptr_i ignored.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               any_o
);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Isolate the lowest set request bit.
    assign gnt_o = req_i & (~req_i + NUM_REQ'(1));
`else
    localparam int SUM_W = PTR_W + 1;

    // Walk the requesters starting at the pointer; first active one wins.
    always_comb begin
        logic [SUM_W-1:0] idx;
        logic             found;
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_i} + SUM_W'(k);
            if (idx >= SUM_W'(NUM_REQ)) begin
                idx = idx - SUM_W'(NUM_REQ);
            end
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                gnt_o[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end
`endif

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter between NUM_REQ byte streams, one packet at a
// time, and sequences the transmit / is_transmitting handshake per byte.
// Build option: UART_TX_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) and removes the round-robin pointer.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no owner; pick one as soon as any requester is valid
// LOAD       | owner locked; accept its next byte when it is valid
// START      | one-cycle transmit pulse with the registered byte
// WAIT_START | wait for the uart to go busy, or give the byte up on timeout
// WAIT_DONE  | wait for the uart to finish, then next byte or release
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*BYTE_W-1:0] req_byte_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      transmit_o,
    output logic [BYTE_W-1:0]         tx_byte_o,
    input  logic                      is_transmitting_i,
    output logic                      busy_o,
    output logic                      timeout_err_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_ptr;
    logic               ptr_adv;
    logic               post_byte;

    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [BYTE_W-1:0]  owner_byte;
    logic               owner_last;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    // Select the current owner's byte/last and its index from the one-hot grant.
    always_comb begin
        owner_idx  = '0;
        owner_byte = '0;
        owner_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_byte = req_byte_i[i*BYTE_W +: BYTE_W];
                owner_last = req_last_i[i];
            end
        end
    end

    assign next_ptr = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    logic unused_ptr_adv;
    assign unused_ptr_adv = ptr_adv ^ (^next_ptr);
    assign pick_ptr       = '0;
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign ptr_d    = ptr_adv ? next_ptr : ptr_q;
    assign pick_ptr = ptr_q;

    // Round-robin pointer: advances past the owner when its packet ends.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        byte_d        = byte_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        ptr_adv       = 1'b0;
        post_byte     = 1'b0;
        req_ready_o   = '0;
        transmit_o    = 1'b0;
        timeout_err_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                req_ready_o = grant_q & req_valid_i;
                if (|(grant_q & req_valid_i)) begin
                    byte_d  = owner_byte;
                    last_d  = owner_last;
                    state_d = START;
                end
            end
            START: begin
                transmit_o = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_START;
            end
            WAIT_START: begin
                if (is_transmitting_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    timeout_err_o = 1'b1;
                    post_byte     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!is_transmitting_i) begin
                    post_byte = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A finished (or lost) byte either ends the packet or fetches the next one.
        if (post_byte) begin
            if (last_q) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_adv = 1'b1;
            end else begin
                state_d = LOAD;
            end
        end
    end

    // State, grant, byte/last and timeout counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o   = grant_q;
    assign tx_byte_o = byte_q;
    assign busy_o    = (state_q != IDLE);

endmodule
